// File: rtl/sm4_pkg.sv
// SM4 shared definitions: FSM states, FK constants, S-box and the round transforms
// used by both the key schedule and the data path.
package sm4_pkg;

    typedef enum logic [1:0] {S_IDLE, S_KEXP, S_CRYPT, S_DONE} state_t;

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    // Entry 0 sits in the top byte, so entry a lives at bit offset (255 - a) * 8.
    localparam logic [2047:0] SBOX_TBL = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox8(input logic [7:0] a);
        logic [10:0] w_off;
        w_off = {~a, 3'b000};
        return SBOX_TBL[w_off +: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox8(a[31:24]), sbox8(a[23:16]), sbox8(a[15:8]), sbox8(a[7:0])};
    endfunction

    function automatic logic [31:0] l_data(input logic [31:0] b);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    // Byte j of CK(i) is (4i + j) * 7 mod 256, byte 0 in the top position.
    function automatic logic [31:0] ck_word(input logic [4:0] idx);
        logic [31:0] w;
        logic [7:0]  t;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            t = {1'b0, idx, 2'b00} + 8'(j);
            w = {w[23:0], t * 8'd7};
        end
        return w;
    endfunction

endpackage

// File: rtl/sm4_iter_core_round.sv
// One combinational SM4 round; i_key_mode picks T' (key schedule) or T (data).
module sm4_round_unit
    import sm4_pkg::*;
(
    input  logic         i_key_mode,
    input  logic [127:0] i_state,
    input  logic [31:0]  i_rk,
    output logic [127:0] o_state
);
    logic [31:0] w_mix, w_sub, w_lin;

    assign w_mix   = i_state[95:64] ^ i_state[63:32] ^ i_state[31:0] ^ i_rk;
    assign w_sub   = tau(w_mix);
    assign w_lin   = i_key_mode ? l_key(w_sub) : l_data(w_sub);
    assign o_state = {i_state[95:0], i_state[127:96] ^ w_lin};

endmodule

// File: rtl/sm4_iter_core.sv
// Iterative SM4 core: RPC rounds per clock, cached round-key bank,
// valid/ready handshakes on both sides.
module sm4_iter_core
    import sm4_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic         key_new,
    input  logic [127:0] key_in,
    input  logic [127:0] text_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] result_out,
    output logic         key_loaded
);
    localparam int ITER = 32 / RPC;
    localparam int CW   = $clog2(ITER);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_k, r_x, r_result;
    logic          r_dec, r_out_valid, r_key_loaded;
    logic [31:0]   r_bank [32];

    logic [RPC:0][127:0]  w_kst, w_xst;
    logic [RPC-1:0][4:0]  w_idx;
    logic [RPC-1:0][31:0] w_ck, w_drk;
    logic                 w_accept, w_last;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == CW'(ITER - 1));
    assign out_valid  = r_out_valid;
    assign result_out = r_result;
    assign key_loaded = r_key_loaded;
    assign w_kst[0]   = r_k;
    assign w_xst[0]   = r_x;

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        assign w_idx[j] = 5'(int'(r_cnt) * RPC + j);
        assign w_ck[j]  = ck_word(w_idx[j]);
        // Decrypt walks the bank backwards: 31 - i is the bitwise inverse of i.
        assign w_drk[j] = r_dec ? r_bank[~w_idx[j]] : r_bank[w_idx[j]];

        sm4_round_unit u_key (
            .i_key_mode (1'b1),
            .i_state    (w_kst[j]),
            .i_rk       (w_ck[j]),
            .o_state    (w_kst[j+1])
        );

        sm4_round_unit u_dat (
            .i_key_mode (1'b0),
            .i_state    (w_xst[j]),
            .i_rk       (w_drk[j]),
            .o_state    (w_xst[j+1])
        );
    end

    always_ff @(posedge clk) begin
        if (r_state == S_KEXP) begin
            for (int j = 0; j < RPC; j++) r_bank[w_idx[j]] <= w_kst[j+1][31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_k          <= '0;
            r_x          <= '0;
            r_dec        <= 1'b0;
            r_result     <= '0;
            r_out_valid  <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE && out_ready) r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_x   <= text_in;
                        r_k   <= key_in ^ FK;
                        r_dec <= in_decrypt;
                        r_cnt <= '0;
                        if (key_new || !r_key_loaded) begin
                            r_state      <= S_KEXP;
                            r_key_loaded <= 1'b0;
                        end else begin
                            r_state <= S_CRYPT;
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_KEXP: begin
                    r_k   <= w_kst[RPC];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_key_loaded <= 1'b1;
                        r_state      <= S_CRYPT;
                    end
                end
                S_CRYPT: begin
                    r_x   <= w_xst[RPC];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_result    <= {w_xst[RPC][31:0], w_xst[RPC][63:32],
                                        w_xst[RPC][95:64], w_xst[RPC][127:96]};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sm4_iter_core.md
Name: sm4_iter_core

Overview:
Parametrised iterative SM4 block cipher core. It is the successor to the single-round-per-cycle encrypt-only loop, and adds the following:
- encrypt/decrypt mode select
- a configurable unroll factor (rounds per cycle)
- a stored round-key bank, so a loaded key is reused across blocks without re-expansion
- valid/ready handshakes on both input and output

It sits between the host data-path buffers and the mode logic (ECB/CBC wrappers).

Parameters:
RPC, 1, SM4 rounds evaluated per clock; legal values 1, 2, 4, 8; the core elaborates RPC key-expansion and RPC data round instances in series.
ITER, 32/RPC, derived (localparam): cycles per key expansion or per block.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  job request; the job is accepted on a clk edge where in_valid && in_ready
in_ready  out  1  core can accept a job
in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept
key_new  in  1  1 = expand key_in before processing; 0 = reuse the stored round keys; sampled at accept
key_in  in  128  user key MK, MSB-first word order; sampled at accept
text_in  in  128  plaintext or ciphertext block; sampled at accept
out_valid  out  1  result_out is valid
out_ready  in  1  downstream accepts the result; transfer occurs on a clk edge where out_valid && out_ready
result_out  out  128  ciphertext or plaintext, word order (X35, X34, X33, X32)
key_loaded  out  1  the round-key bank holds a complete expansion

Behaviour:
- Reset (reset_n = 0, asynchronous) forces the following, and aborts any job in flight with no output produced:
  - FSM = IDLE, round counter = 0
  - in_ready = 1, out_valid = 0, result_out = 0, key_loaded = 0
- FSM states: IDLE, KEXP, CRYPT, DONE.
- IDLE:
  - in_ready = 1.
  - On accept, register text_in, in_decrypt and key_in; clear the counter.
  - Go to KEXP if key_new = 1 or key_loaded = 0; otherwise go to CRYPT.
- KEXP:
  - Initialise K0..K3 = MK ^ FK.
  - Each cycle compute RPC round keys rk[i] = K(i+4) = K(i) ^ T'(K(i+1) ^ K(i+2) ^ K(i+3) ^ CK(i)) and write them to bank entries counter*RPC .. counter*RPC+RPC-1.
  - After ITER cycles: key_loaded = 1, clear the counter, go to CRYPT.
  - key_loaded is cleared on entry to KEXP, so an aborted expansion never leaves a stale flag.
- CRYPT:
  - Each cycle apply RPC rounds X(i+4) = X(i) ^ T(X(i+1) ^ X(i+2) ^ X(i+3) ^ rk_sel(i)).
  - Round-key select: encrypt uses rk_sel(i) = rk[i]; decrypt uses rk_sel(i) = rk[31-i].
  - After ITER cycles, register the reversed output words into result_out and go to DONE.
- DONE:
  - out_valid = 1; result_out is held stable until the transfer.
  - in_ready = out_ready. This gives back-to-back operation: output transfer and new-job accept on the same edge, with the next state chosen as in IDLE.
  - If out_ready = 1 and in_valid = 0, go to IDLE.
  - If out_ready = 0, hold state.
- KEXP and CRYPT: in_ready = 0. in_valid is ignored; the upstream holds its request.
- Latency, from accept edge to the first edge with out_valid = 1:
  - 2*ITER cycles with key expansion (64 at RPC = 1, 8 at RPC = 8)
  - ITER cycles with a cached key
- Throughput with a cached key: one block per ITER+1 cycles with out_ready held at 1; the DONE cycle overlaps the accept.
- key_new = 0 with key_loaded = 0 silently performs the expansion using key_in.
- Round-key bank: 32 x 32-bit registers; written only in KEXP; read by a 5-bit index (counter*RPC + j) or its bitwise inverse for decrypt.
- CK(i): byte j = ((4i + j) * 7) mod 256, computed combinationally from the 5-bit index.
- All arithmetic is XOR/rotate only. The counter is log2(ITER) bits and never wraps mid-phase.

Decomposition:
- Package sm4_pkg:
  - FK constant words A3B1BAC6, 56AA3350, 677D9197, B27022DC
  - S-box function sbox8
  - functions tau, L (rotates 2, 10, 18, 24) and L' (rotates 13, 23)
  - function ck_word(idx)
  - FSM state typedef
- Sub-module sm4_round_unit:
  - A combinational single round with a mode input selecting the key-schedule transform (T') or the data transform (T).
  - The core instantiates 2*RPC copies.

Test Plan:
- Encrypt with new key, RPC = 1, MK = text = 0123456789abcdeffedcba9876543210 -> result 681edf34d206965e86b3e94f536e4246; out_valid first seen 64 cycles after accept; key_loaded = 1.
- Decrypt with cached key, text = 681edf34d206965e86b3e94f536e4246 -> result 0123456789abcdeffedcba9876543210 after 32 cycles.
- Back-to-back cached-key encrypt of 8 blocks with out_ready tied high -> one result every 33 cycles; compare against a reference model.
- Backpressure: out_ready = 0 for 10 cycles in DONE -> result_out and out_valid stable; in_ready = 0; a held in_valid is accepted on the edge where out_ready rises.
- Reset mid-KEXP and mid-CRYPT -> outputs take reset values immediately; key_loaded = 0; next job with key_new = 0 still produces 681edf34... via the forced expansion.
- Repeat the first vector for RPC = 2, 4, 8 -> identical results with latency 32, 16 and 8 cycles; 1,000,000 chained encryptions at RPC = 8 -> 595298c7c6fd271f0402f804c33d3f66.
